// File: rtl/sercmp_pkg.sv
// Shared definitions for the serial magnitude comparator:
// FSM state type, cascade reset value and operand-width legality helper.
package sercmp_pkg;

  // Controller states: waiting for a request, or stepping through nibbles.
  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  // Cascade seed {g, l, e}: "equal so far" before any nibble is seen.
  localparam logic [2:0] CASCADE_RST = 3'b001;

  // Operand width must be a whole, non-zero number of nibbles.
  function automatic bit width_ok(input int w);
    return (w >= 32'sd4) && ((w % 32'sd4) == 32'sd0);
  endfunction

endpackage

// File: rtl/cmp_nibble_cascade.sv
// One cascadable 4-bit magnitude comparator slice (purely combinational).
// A lower-significance verdict arrives on the cascade inputs and is
// overridden whenever this nibble differs.
module cmp_nibble_cascade (
  input  logic [3:0] i_a,
  input  logic [3:0] i_b,
  input  logic       i_g_in,
  input  logic       i_l_in,
  input  logic       i_e_in,
  output logic       o_g,
  output logic       o_l,
  output logic       o_e
);

  logic w_gt;
  logic w_lt;
  logic w_eq;

  assign w_gt = (i_a > i_b);
  assign w_lt = (i_a < i_b);
  assign w_eq = (i_a == i_b);

  assign o_g = w_gt | (w_eq & i_g_in);
  assign o_l = w_lt | (w_eq & i_l_in);
  assign o_e = w_eq & i_e_in;

endmodule

// File: rtl/serial_cmp_ctrl.sv
// Serial N-bit magnitude comparator: steps one 4-bit cascade slice over the
// latched operands LSB-nibble first, one nibble per clock, and presents a
// registered G/L/E result with a one-cycle done pulse.
// Optional build macro: SERCMP_SIGNED_EN (two's-complement operands; the
// sign bit of the top nibble pair is inverted before comparison).
module serial_cmp_ctrl
  import sercmp_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_start,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  output logic             o_busy,
  output logic             o_done,
  output logic             o_g,
  output logic             o_l,
  output logic             o_e
);

  localparam int N  = WIDTH / 4;
  localparam int IW = (N > 1) ? $clog2(N) : 1;
  localparam logic [IW-1:0] IDX_LAST = IW'(N - 1);
  localparam logic [IW-1:0] IDX_ONE  = IW'(32'd1);

  if (!width_ok(WIDTH)) begin : g_width_bad
    $error("serial_cmp_ctrl: WIDTH must be a positive multiple of 4");
  end

  state_t          r_state;
  state_t          w_state_nxt;
  logic            w_accept;
  logic            w_finish;
  logic            w_last;
  logic [IW-1:0]   r_idx;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic            r_cg;
  logic            r_cl;
  logic            r_ce;
  logic [3:0]      w_a_nib;
  logic [3:0]      w_b_nib;
  logic [3:0]      w_a_cmp;
  logic [3:0]      w_b_cmp;
  logic            w_g;
  logic            w_l;
  logic            w_e;
  logic            r_busy;
  logic            r_done;
  logic            r_g_out;
  logic            r_l_out;
  logic            r_e_out;

  assign w_last = (r_idx == IDX_LAST);

  // Select nibble idx of each latched operand.
  always_comb begin
    w_a_nib = 4'h0;
    w_b_nib = 4'h0;
    for (int k = 0; k < N; k++) begin
      w_a_nib = (r_idx == IW'(k)) ? r_a[4*k +: 4] : w_a_nib;
      w_b_nib = (r_idx == IW'(k)) ? r_b[4*k +: 4] : w_b_nib;
    end
  end

`ifdef SERCMP_SIGNED_EN
  // Flip the sign bits on the top nibble so signed order maps to unsigned order.
  always_comb begin
    w_a_cmp = {w_a_nib[3] ^ w_last, w_a_nib[2:0]};
    w_b_cmp = {w_b_nib[3] ^ w_last, w_b_nib[2:0]};
  end
`else
  assign w_a_cmp = w_a_nib;
  assign w_b_cmp = w_b_nib;
`endif

  cmp_nibble_cascade u_slice (
    .i_a    (w_a_cmp),
    .i_b    (w_b_cmp),
    .i_g_in (r_cg),
    .i_l_in (r_cl),
    .i_e_in (r_ce),
    .o_g    (w_g),
    .o_l    (w_l),
    .o_e    (w_e)
  );

  // FSM state register.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic: accept a request in IDLE, finish on the last nibble.
  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_finish    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (i_start) begin
          w_state_nxt = ST_RUN;
          w_accept    = 1'b1;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (w_last) begin
          w_state_nxt = ST_IDLE;
          w_finish    = 1'b1;
        end else begin
          w_state_nxt = ST_RUN;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // Operand latches: captured only on the accepting edge.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_a <= '0;
      r_b <= '0;
    end else if (w_accept) begin
      r_a <= i_a;
      r_b <= i_b;
    end else begin
      r_a <= r_a;
      r_b <= r_b;
    end
  end

  // Nibble index and cascade registers: seeded on accept, advanced in RUN.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_idx                <= '0;
      {r_cg, r_cl, r_ce}   <= CASCADE_RST;
    end else if (w_accept) begin
      r_idx                <= '0;
      {r_cg, r_cl, r_ce}   <= CASCADE_RST;
    end else if (r_state == ST_RUN) begin
      r_idx                <= w_last ? '0 : (r_idx + IDX_ONE);
      {r_cg, r_cl, r_ce}   <= {w_g, w_l, w_e};
    end else begin
      r_idx                <= r_idx;
      {r_cg, r_cl, r_ce}   <= {r_cg, r_cl, r_ce};
    end
  end

  // Status outputs: busy rises on the first RUN edge and drops on the
  // result edge; done pulses for the cycle after the result edge.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_busy <= 1'b0;
      r_done <= 1'b0;
    end else begin
      r_busy <= (r_state == ST_RUN) && !w_last;
      r_done <= w_finish;
    end
  end

  // Result registers: hold the previous verdict until the next result edge.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_g_out <= 1'b0;
      r_l_out <= 1'b0;
      r_e_out <= 1'b0;
    end else if (w_finish) begin
      r_g_out <= w_g;
      r_l_out <= w_l;
      r_e_out <= w_e;
    end else begin
      r_g_out <= r_g_out;
      r_l_out <= r_l_out;
      r_e_out <= r_e_out;
    end
  end

  assign o_busy = r_busy;
  assign o_done = r_done;
  assign o_g    = r_g_out;
  assign o_l    = r_l_out;
  assign o_e    = r_e_out;

endmodule

// File: tb/tb_serial_cmp_ctrl.sv
// Self-checking bench for serial_cmp_ctrl (WIDTH=16): directed vector table,
// multi-cycle corner sequences and random operands against a plain
// arithmetic reference. Honours SERCMP_SIGNED_EN for the expected ordering.
module tb_serial_cmp_ctrl;

  localparam int W     = 16;
  localparam int N     = W / 4;
  localparam int LIMIT = 3 * N + 8;

  logic         clk;
  logic         rst;
  logic         start;
  logic [W-1:0] a_in;
  logic [W-1:0] b_in;
  logic         busy;
  logic         done;
  logic         g;
  logic         l;
  logic         e;

  int n_checks = 0;
  int n_fail   = 0;

  serial_cmp_ctrl #(.WIDTH(W)) dut (
    .i_clk   (clk),
    .i_rst   (rst),
    .i_start (start),
    .i_a     (a_in),
    .i_b     (b_in),
    .o_busy  (busy),
    .o_done  (done),
    .o_g     (g),
    .o_l     (l),
    .o_e     (e)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [2:0]   exp;   // {G, L, E}
  } vec_t;

  vec_t vecs [7];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference ordering computed directly from the operand values.
  function automatic logic [2:0] ref_cmp(input logic [W-1:0] x, input logic [W-1:0] y);
`ifdef SERCMP_SIGNED_EN
    if ($signed(x) > $signed(y))      return 3'b100;
    else if ($signed(x) < $signed(y)) return 3'b010;
    else                              return 3'b001;
`else
    if (x > y)      return 3'b100;
    else if (x < y) return 3'b010;
    else            return 3'b001;
`endif
  endfunction

  // Present a request at the current negedge; accepted on the next posedge.
  task automatic launch(input logic [W-1:0] x, input logic [W-1:0] y);
    start = 1'b1;
    a_in  = x;
    b_in  = y;
  endtask

  // Complete a launched request: scramble operands after acceptance, optionally
  // poke start while running, and measure latency, busy cycles and stability.
  task automatic finish_cmp(input bit poke, output int lat, output int busy_cnt,
                            output logic [2:0] res, output bit stable);
    logic [2:0] prev;
    @(negedge clk);
    start    = 1'b0;
    prev     = {g, l, e};
    stable   = 1'b1;
    lat      = -1;
    busy_cnt = 0;
    res      = 3'b000;
    for (int k = 1; k <= LIMIT; k++) begin
      a_in  = W'($urandom);
      b_in  = W'($urandom);
      start = poke ? 1'($urandom_range(0, 1)) : 1'b0;
      @(negedge clk);
      if (busy) busy_cnt++;
      if (done) begin
        lat   = k;
        res   = {g, l, e};
        start = 1'b0;
        break;
      end else if ({g, l, e} != prev) begin
        stable = 1'b0;
      end
    end
    start = 1'b0;
  endtask

  int         lat;
  int         bcnt;
  logic [2:0] res;
  bit         stab;
  int         extra;
  logic [W-1:0] ra;
  logic [W-1:0] rb;

  initial begin
    vecs[0] = '{a: 16'h1234, b: 16'h1234, exp: 3'b001};
    vecs[1] = '{a: 16'h0001, b: 16'h0100, exp: 3'b010};
`ifdef SERCMP_SIGNED_EN
    vecs[2] = '{a: 16'hF000, b: 16'h0FFF, exp: 3'b010};
    vecs[3] = '{a: 16'h8000, b: 16'h7FFF, exp: 3'b010};
`else
    vecs[2] = '{a: 16'hF000, b: 16'h0FFF, exp: 3'b100};
    vecs[3] = '{a: 16'h8000, b: 16'h7FFF, exp: 3'b100};
`endif
    vecs[4] = '{a: 16'h0000, b: 16'h0000, exp: 3'b001};
    vecs[5] = '{a: 16'hFFFF, b: 16'hFFFE, exp: 3'b100};
    vecs[6] = '{a: 16'h1235, b: 16'h1234, exp: 3'b100};

    rst   = 1'b1;
    start = 1'b0;
    a_in  = '0;
    b_in  = '0;
    repeat (2) @(negedge clk);
    check("reset_outputs", {27'd0, busy, done, g, l, e}, 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // Directed table.
    foreach (vecs[i]) begin
      launch(vecs[i].a, vecs[i].b);
      finish_cmp(1'b0, lat, bcnt, res, stab);
      check($sformatf("vec%0d_glE", i), {29'd0, res}, {29'd0, vecs[i].exp});
      check($sformatf("vec%0d_latency", i), lat, N);
      check($sformatf("vec%0d_busy_cycles", i), bcnt, N - 1);
      check($sformatf("vec%0d_hold", i), {31'd0, stab}, 32'd1);
      @(negedge clk);
      check($sformatf("vec%0d_done_pulse", i), {31'd0, done}, 32'd0);
    end

    // Back-to-back: second start issued in the done cycle.
    launch(16'hF000, 16'h0FFF);
    finish_cmp(1'b0, lat, bcnt, res, stab);
    check("b2b_first_latency", lat, N);
    launch(16'd5, 16'd9);
    finish_cmp(1'b0, lat, bcnt, res, stab);
    check("b2b_second_latency", lat, N);
    check("b2b_second_glE", {29'd0, res}, 32'd2);

    // Start pokes while running produce no extra done.
    launch(16'h00FF, 16'h00FE);
    finish_cmp(1'b1, lat, bcnt, res, stab);
    check("poke_latency", lat, N);
    check("poke_glE", {29'd0, res}, 32'd4);
    extra = 0;
    for (int k = 0; k < 2 * N; k++) begin
      @(negedge clk);
      if (done) extra++;
    end
    check("poke_no_extra_done", extra, 0);

    // Reset in the middle of a run aborts everything immediately.
    launch(16'h2222, 16'h1111);
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    #1;
    check("midrun_reset", {27'd0, busy, done, g, l, e}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    extra = 0;
    for (int k = 0; k < 2 * N; k++) begin
      @(negedge clk);
      if (done) extra++;
    end
    check("aborted_no_done", extra, 0);
    launch(16'h0010, 16'h0011);
    finish_cmp(1'b0, lat, bcnt, res, stab);
    check("post_reset_latency", lat, N);
    check("post_reset_glE", {29'd0, res}, 32'd2);

    // Random operands against the reference.
    for (int i = 0; i < 40; i++) begin
      ra = W'($urandom);
      rb = (i % 5 == 0) ? ra : W'($urandom);
      if (i % 7 == 3) rb = ra ^ (W'(1) << $urandom_range(0, W - 1));
      launch(ra, rb);
      finish_cmp(1'(i % 2), lat, bcnt, res, stab);
      check($sformatf("rand%0d_glE a=%0h b=%0h", i, ra, rb), {29'd0, res}, {29'd0, ref_cmp(ra, rb)});
      check($sformatf("rand%0d_latency", i), lat, N);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
